// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised ALU with registered results and flags.
// Single-cycle ops: NOP, ADD, SUB, AND, NOT, OR, EQ, BRANCH.
// Optional feature macro: ALU_MUL_EN adds an iterative shift-add multiplier
// (opcode 1000, WIDTH+1 cycles). Without it, opcode 1000 completes as illegal
// and result_hi is tied to zero.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic [3:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic              co,
    output logic              eq,
    output logic              branch,
    output logic [ADDR_W-1:0] br_target,
    output logic              illegal
);

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_ADD    = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_AND    = 4'b0011;
    localparam logic [3:0] OP_NOT    = 4'b0100;
    localparam logic [3:0] OP_OR     = 4'b0101;
    localparam logic [3:0] OP_EQ     = 4'b0110;
    localparam logic [3:0] OP_BRANCH = 4'b0111;
    localparam logic [3:0] OP_MUL    = 4'b1000;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t state_reg;
    state_t state_next;

    logic              accept;
    logic              single_go;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic              a_eq_b;

    logic [WIDTH-1:0]  alu_res;
    logic              alu_co;
    logic              alu_branch;
    logic [ADDR_W-1:0] alu_target;
    logic              alu_illegal;
    logic              eq_load;

    logic [WIDTH-1:0]  result_reg;
    logic              co_reg;
    logic              eq_reg;
    logic              branch_reg;
    logic [ADDR_W-1:0] br_target_reg;
    logic              illegal_reg;

    // Ready is a pure function of state and the consumer's ready.
    assign in_ready  = (state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready);
    assign out_valid = (state_reg == S_DONE);
    assign accept    = in_valid && in_ready;

    // Shared adder/subtractor; the extra top bit is carry or borrow.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign a_eq_b   = (a == b);

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             is_mul;
    logic             mul_finish;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0] result_hi_reg;

    assign is_mul     = (op == OP_MUL);
    assign single_go  = accept && !is_mul;
    // The cycle after the last iteration transfers the product to the outputs.
    assign mul_finish = (state_reg == S_EXEC) && (cnt_reg == CNT_W'(WIDTH));

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole product right, carry included.
    assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} +
                       (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    assign prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
`else
    assign single_go = accept;
`endif

    // Decode the opcode into next result and flag values for single-cycle ops.
    always_comb begin
        alu_res     = '0;
        alu_co      = 1'b0;
        alu_branch  = 1'b0;
        alu_target  = '0;
        alu_illegal = 1'b0;
        eq_load     = 1'b0;
        case (op)
            OP_NOP: begin
                alu_res = '0;
            end
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_co  = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_co  = diff_ext[WIDTH];
            end
            OP_AND: alu_res = a & b;
            OP_NOT: alu_res = ~a;
            OP_OR:  alu_res = a | b;
            OP_EQ: begin
                alu_res = {{(WIDTH-1){1'b0}}, a_eq_b};
                eq_load = 1'b1;
            end
            OP_BRANCH: begin
                alu_branch = eq_reg;
                alu_target = eq_reg ? br_addr : '0;
            end
`ifdef ALU_MUL_EN
            OP_MUL: alu_res = '0;
`else
            OP_MUL: alu_illegal = 1'b1;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

    // Next-state logic for the IDLE / EXEC / DONE handshake controller.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    state_next = is_mul ? S_EXEC : S_DONE;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef ALU_MUL_EN
            S_EXEC: begin
                if (mul_finish) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        state_next = is_mul ? S_EXEC : S_DONE;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Persistent equality flag: only an accepted EQ op changes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_reg <= 1'b0;
        end else if (accept && eq_load) begin
            eq_reg <= a_eq_b;
        end
    end

    // Result and flag registers; they only change when a new result lands,
    // which keeps them stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            co_reg        <= 1'b0;
            branch_reg    <= 1'b0;
            br_target_reg <= '0;
            illegal_reg   <= 1'b0;
        end else if (single_go) begin
            result_reg    <= alu_res;
            co_reg        <= alu_co;
            branch_reg    <= alu_branch;
            br_target_reg <= alu_target;
            illegal_reg   <= alu_illegal;
        end
`ifdef ALU_MUL_EN
        else if (mul_finish) begin
            result_reg    <= prod_reg[WIDTH-1:0];
            co_reg        <= 1'b0;
            branch_reg    <= 1'b0;
            br_target_reg <= '0;
            illegal_reg   <= 1'b0;
        end
`endif
    end

`ifdef ALU_MUL_EN
    // Iterative multiplier: load on acceptance, one shift-add step per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            mcand_reg <= '0;
            prod_reg  <= '0;
        end else if (accept && is_mul) begin
            cnt_reg   <= '0;
            mcand_reg <= a;
            prod_reg  <= {{WIDTH{1'b0}}, b};
        end else if ((state_reg == S_EXEC) && !mul_finish) begin
            cnt_reg   <= cnt_reg + 1'b1;
            prod_reg  <= prod_next;
        end
    end

    // Upper product half; every single-cycle op clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_hi_reg <= '0;
        end else if (single_go) begin
            result_hi_reg <= '0;
        end else if (mul_finish) begin
            result_hi_reg <= prod_reg[2*WIDTH-1:WIDTH];
        end
    end

    assign result_hi = result_hi_reg;
`else
    assign result_hi = '0;
`endif

    assign result    = result_reg;
    assign co        = co_reg;
    assign eq        = eq_reg;
    assign branch    = branch_reg;
    assign br_target = br_target_reg;
    assign illegal   = illegal_reg;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the processor's 8-bit ALU. It executes the same operation set (add, sub, and, not, or, equality compare, branch-on-equal) at configurable data and branch-address width. Results, carry, equality and branch flags are registered. The block adds a valid/ready input and output handshake, a persistent equality flag, and an optional iterative multiplier. It sits between decode and writeback/PC-select in the processor datapath.

## Interface
- WIDTH, 8, operand/result width (≥2)
- ADDR_W, 6, branch address width
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  operation request valid
- IN_READY  out  1  block can accept a request this cycle
- A  in  WIDTH  operand 1
- B  in  WIDTH  operand 2
- BR_ADDR  in  ADDR_W  branch target address
- OP  in  4  opcode: 0000 NOP, 0001 ADD, 0010 SUB, 0011 AND, 0100 NOT, 0101 OR, 0110 EQ, 0111 BRANCH, 1000 MUL, others illegal
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer accepts result
- RESULT  out  WIDTH  result (low half for MUL)
- RESULT_HI  out  WIDTH  upper product half for MUL; 0 otherwise
- CO  out  1  carry (ADD) / borrow (SUB)
- EQ  out  1  persistent equality flag
- BRANCH  out  1  branch taken
- BR_TARGET  out  ADDR_W  BR_ADDR if taken, else 0
- ILLEGAL  out  1  opcode was illegal/not compiled in

## Operation
- An operation is accepted on the cycle where IN_VALID && IN_READY. A, B, BR_ADDR and OP are captured on that edge.
- FSM states:
  - IDLE: IN_READY=1.
  - EXEC: MUL only; IN_READY=0.
  - DONE: OUT_VALID=1; IN_READY=OUT_READY.
- Transitions:
  - IDLE→DONE on acceptance of any non-MUL op.
  - IDLE→EXEC on MUL.
  - EXEC→DONE after WIDTH iterations.
  - DONE→IDLE on OUT_READY with no new acceptance.
  - DONE→DONE/EXEC on OUT_READY with a same-cycle acceptance.
- Arithmetic, all unsigned, results mod 2^WIDTH:
  - ADD: RESULT=A+B; CO=carry out.
  - SUB: RESULT=A−B; CO=1 iff A<B.
  - AND: A&B. OR: A|B. NOT: ~A.
  - EQ: RESULT={0…,A==B}. The EQ flag register is loaded with A==B.
  - BRANCH: RESULT=0; BRANCH=EQ flag; BR_TARGET=BR_ADDR if EQ flag else 0.
  - MUL: shift-add over WIDTH cycles; {RESULT_HI,RESULT}=A*B.
  - NOP: RESULT=0, no flag change.
- CO, BRANCH, RESULT_HI and ILLEGAL are 0 for ops that do not define them.
- EQ flag changes only on an EQ op or reset. It holds across all other ops.
- Illegal opcode: completes like a single-cycle op with RESULT=0, all other flags 0 (EQ held), ILLEGAL=1.
- While OUT_VALID && !OUT_READY, every output is held stable.

## Timing
- Reset values: OUT_VALID, RESULT, RESULT_HI, CO, EQ, BRANCH, BR_TARGET and ILLEGAL are all 0; IN_READY=1; FSM in IDLE.
- Single-cycle op latency: accepted at edge N → OUT_VALID at edge N+1.
- MUL latency: accepted at edge N → OUT_VALID at edge N+WIDTH+1.
- Throughput: one single-cycle op per clock when OUT_READY=1.
- IN_READY is combinational from state and OUT_READY. There is no other input→output combinational path.
- Reset mid-operation: asserting RST_N low aborts immediately and asynchronously. All outputs take reset values; the partial product is discarded.
- IN_VALID is ignored while IN_READY=0. Operands need not be held after acceptance.

## Configuration
- ALU_MUL_EN defined: MUL (1000) is implemented as above.
- ALU_MUL_EN undefined: EXEC state and multiplier are removed. OP 1000 is treated as illegal (1-cycle, ILLEGAL=1, RESULT=0). RESULT_HI is tied to 0.

## Test plan
All scenarios use WIDTH=8, ADDR_W=6.
- ADD: 18+3 → RESULT=21, CO=0, OUT_VALID one cycle after accept. Then 255+255 → RESULT=254, CO=1.
- SUB: 0−7 → RESULT=249, CO=1. Then 7−7 → RESULT=0, CO=0.
- Logic: 0x05&0x15 → 0x05; ~0x00 → 0xFF; 0x15|0x03 → 0x17. All with CO=BRANCH=0.
- Branch:
  - EQ 0x15,0x15 → RESULT=1, EQ=1. Then BRANCH with BR_ADDR=36 → BRANCH=1, BR_TARGET=36, EQ still 1.
  - EQ 0x17,0x15 → EQ=0. Then BRANCH with BR_ADDR=44 → BRANCH=0, BR_TARGET=0.
- MUL (ALU_MUL_EN defined):
  - 200*100 → RESULT=0x20, RESULT_HI=0x4E, OUT_VALID exactly 9 cycles after accept, IN_READY=0 throughout.
  - Without the macro: same stimulus → ILLEGAL=1, RESULT=0, 1-cycle latency.
- Backpressure/reset:
  - Hold OUT_READY=0 for 3 cycles after an ADD → outputs stable, IN_READY=0. Raise OUT_READY with IN_VALID=1 → new op accepted that cycle.
  - Drop RST_N during MUL iteration 4 → all outputs 0 at once. After release: IN_READY=1, EQ=0.
